// File: rtl/f_axi_pkg.sv
// rtl/f_axi_pkg.sv - shared AXI property-block types and width helpers
// Purpose: response codes and counter-width functions shared by the
// AXI4-lite master-port and slave-port property blocks.
package f_axi_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_e;

  // Width of an outstanding-transaction counter for a given channel limit.
  function automatic int f_cw(input int outstand_max);
    return (outstand_max <= 2) ? 1 : $clog2(outstand_max);
  endfunction

  // Width needed to hold the value max_val (at least one bit, so a
  // disabled check of limit 0 still has a legal vector).
  function automatic int f_cnt_w(input int max_val);
    return (max_val <= 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/f_axil_slave_if.sv
// rtl/f_axil_slave_if.sv - AXI4-lite bus bundle for the slave-port property block
// Purpose: groups the five AXI4-lite channels.
// Modports:
//   master - drives requests, bready/rready
//   slave  - drives readies and responses
//   mon    - observes every signal (used by the property block)
interface f_axil_slave_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);

  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

  modport mon (
    input awaddr, awprot, awvalid, awready,
    input wdata, wstrb, wvalid, wready,
    input bresp, bvalid, bready,
    input araddr, arprot, arvalid, arready,
    input rdata, rresp, rvalid, rready
  );

endinterface

// File: rtl/f_axil_chan_stable.sv
// rtl/f_axil_chan_stable.sv - valid/payload stability and stall checker for one channel
// Purpose: flags a valid or payload that changes while stalled, and counts
// consecutive valid&&!ready cycles against MAX_STALL.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   past_ok_i       previous cycle exists and was out of reset
//   valid_i/ready_i channel handshake
//   payload_i       channel payload that must stay stable while stalled
//   stable_fail_o   stability rule broken this cycle
//   stall_fail_o    stall has lasted MAX_STALL cycles
// AS_ASSERT=1: the sender is the slave, so stability is asserted and the
// stall limit (on the master's ready) is assumed; AS_ASSERT=0 is the reverse.
module f_axil_chan_stable
  import f_axi_pkg::*;
#(
  parameter int PAYLOAD_WIDTH = 1,
  parameter bit AS_ASSERT     = 1'b0,
  parameter int MAX_STALL     = 0,
  parameter bit F_ASSERT_EN   = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     past_ok_i,
  input  logic                     valid_i,
  input  logic                     ready_i,
  input  logic [PAYLOAD_WIDTH-1:0] payload_i,
  output logic                     stable_fail_o,
  output logic                     stall_fail_o
);

  localparam int SW = f_cnt_w(MAX_STALL);

  logic                     valid_q;
  logic                     ready_q;
  logic [PAYLOAD_WIDTH-1:0] payload_q;
  logic [SW-1:0]            stall_q;
  logic [SW-1:0]            stall_d;

  // Saturates at MAX_STALL; a limit of 0 keeps the counter pinned at 0.
  always_comb begin
    stall_d = '0;
    if (valid_i && !ready_i) begin
      stall_d = (stall_q == SW'(MAX_STALL)) ? stall_q : stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q   <= 1'b0;
      ready_q   <= 1'b0;
      payload_q <= '0;
      stall_q   <= '0;
    end else begin
      valid_q   <= valid_i;
      ready_q   <= ready_i;
      payload_q <= payload_i;
      stall_q   <= stall_d;
    end
  end

  // A reset in the current cycle legitimately drops a stalled valid.
  assign stable_fail_o = past_ok_i && rst && valid_q && !ready_q &&
                         (!valid_i || (payload_i != payload_q));
  assign stall_fail_o  = (MAX_STALL > 0) && (stall_q >= SW'(MAX_STALL));

  if (F_ASSERT_EN && AS_ASSERT) begin : g_resp_chan
    always_ff @(posedge clk) begin
      a_stable: assert (!stable_fail_o);
      m_stall:  assume (!stall_fail_o);
    end
  end else if (F_ASSERT_EN) begin : g_req_chan
    always_ff @(posedge clk) begin
      m_stable: assume (!stable_fail_o);
      a_stall:  assert (!stall_fail_o);
    end
  end

endmodule

// File: rtl/f_axil_slave.sv
// rtl/f_axil_slave.sv - AXI4-lite slave-port property block
// Purpose: constrains master-driven signals, asserts slave-driven signals,
// and exports outstanding AR/AW/W counts for induction.
// Ports:
//   clk, rst                   clock, synchronous active-low reset
//   s_axil                     observed AXI4-lite bus (mon modport)
//   f_axil_s_ar_outstanding    reads accepted, no R yet
//   f_axil_s_aw_outstanding    write addresses accepted, no B yet
//   f_axil_s_w_outstanding     write data accepted, no B yet
// F_ASSERT_EN=0 elaborates the checks as flags only (f_assert_fail,
// f_assume_fail) without assert/assume statements.
module f_axil_slave
  import f_axi_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int OUTSTAND_MAX   = 64,
  parameter int MAX_STALL      = 0,
  parameter int MAX_RESP_DELAY = 0,
  parameter bit F_ASSERT_EN    = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  f_axil_slave_if.mon                   s_axil,
  output logic [f_cw(OUTSTAND_MAX)-1:0] f_axil_s_ar_outstanding,
  output logic [f_cw(OUTSTAND_MAX)-1:0] f_axil_s_aw_outstanding,
  output logic [f_cw(OUTSTAND_MAX)-1:0] f_axil_s_w_outstanding
);

  localparam int            CW        = f_cw(OUTSTAND_MAX);
  localparam int            DLW       = f_cnt_w(MAX_RESP_DELAY);
  localparam logic [CW-1:0] CNT_LIMIT = CW'(OUTSTAND_MAX - 1);

  // Deliberately not reset: they describe the trace history itself.
  logic f_past_valid_q = 1'b0;
  logic past_rst_q     = 1'b0;
  logic past_ok;

  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic [CW-1:0]  ar_q, ar_d, aw_q, aw_d, w_q, w_d;
  logic [DLW-1:0] rd_dly_q, rd_dly_d, wr_dly_q, wr_dly_d;
  logic rd_wait, wr_wait;

  logic f_b_early, f_r_early, f_post_rst, f_rd_dly, f_wr_dly;
  logic f_req_in_rst, f_ovf;
  logic aw_stable_fail, aw_stall_fail, w_stable_fail, w_stall_fail;
  logic ar_stable_fail, ar_stall_fail, b_stable_fail, b_stall_fail;
  logic r_stable_fail, r_stall_fail;
  logic f_assert_fail, f_assume_fail;

  always_ff @(posedge clk) begin
    f_past_valid_q <= 1'b1;
    past_rst_q     <= rst;
  end

  assign past_ok = f_past_valid_q && past_rst_q;

  assign ar_hs = s_axil.arvalid && s_axil.arready;
  assign r_hs  = s_axil.rvalid  && s_axil.rready;
  assign aw_hs = s_axil.awvalid && s_axil.awready;
  assign w_hs  = s_axil.wvalid  && s_axil.wready;
  assign b_hs  = s_axil.bvalid  && s_axil.bready;

  assign rd_wait = (ar_q != '0) && !s_axil.rvalid;
  assign wr_wait = (aw_q != '0) && (w_q != '0) && !s_axil.bvalid;

  // Counters clamp at both ends so an illegal response cannot wrap them.
  always_comb begin
    ar_d = ar_q;
    if (ar_hs && !r_hs && ar_q != '1)      ar_d = ar_q + 1'b1;
    else if (r_hs && !ar_hs && ar_q != '0) ar_d = ar_q - 1'b1;

    aw_d = aw_q;
    if (aw_hs && !b_hs && aw_q != '1)      aw_d = aw_q + 1'b1;
    else if (b_hs && !aw_hs && aw_q != '0) aw_d = aw_q - 1'b1;

    w_d = w_q;
    if (w_hs && !b_hs && w_q != '1)        w_d = w_q + 1'b1;
    else if (b_hs && !w_hs && w_q != '0)   w_d = w_q - 1'b1;

    rd_dly_d = '0;
    if (rd_wait) begin
      rd_dly_d = (rd_dly_q == DLW'(MAX_RESP_DELAY)) ? rd_dly_q : rd_dly_q + 1'b1;
    end
    wr_dly_d = '0;
    if (wr_wait) begin
      wr_dly_d = (wr_dly_q == DLW'(MAX_RESP_DELAY)) ? wr_dly_q : wr_dly_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ar_q     <= '0;
      aw_q     <= '0;
      w_q      <= '0;
      rd_dly_q <= '0;
      wr_dly_q <= '0;
    end else begin
      ar_q     <= ar_d;
      aw_q     <= aw_d;
      w_q      <= w_d;
      rd_dly_q <= rd_dly_d;
      wr_dly_q <= wr_dly_d;
    end
  end

  assign f_axil_s_ar_outstanding = ar_q;
  assign f_axil_s_aw_outstanding = aw_q;
  assign f_axil_s_w_outstanding  = w_q;

  // Slave-side rules; only registered counts count, so an AW/W
  // handshake in the same cycle as bvalid does not make it legal.
  assign f_b_early  = rst && s_axil.bvalid && (aw_q == '0 || w_q == '0);
  assign f_r_early  = rst && s_axil.rvalid && (ar_q == '0);
  assign f_post_rst = f_past_valid_q && !past_rst_q && (s_axil.bvalid || s_axil.rvalid);
  assign f_rd_dly   = (MAX_RESP_DELAY > 0) && (rd_dly_q >= DLW'(MAX_RESP_DELAY));
  assign f_wr_dly   = (MAX_RESP_DELAY > 0) && (wr_dly_q >= DLW'(MAX_RESP_DELAY));

  // Master-side rules.
  assign f_req_in_rst = (!rst || !past_rst_q) &&
                        (s_axil.awvalid || s_axil.wvalid || s_axil.arvalid);
  assign f_ovf = rst && ((ar_hs && ar_q >= CNT_LIMIT) ||
                         (aw_hs && aw_q >= CNT_LIMIT) ||
                         (w_hs  && w_q  >= CNT_LIMIT));

  f_axil_chan_stable #(.PAYLOAD_WIDTH(ADDR_WIDTH + 3), .AS_ASSERT(1'b0),
    .MAX_STALL(MAX_STALL), .F_ASSERT_EN(F_ASSERT_EN)) u_aw (
    .clk(clk), .rst(rst), .past_ok_i(past_ok),
    .valid_i(s_axil.awvalid), .ready_i(s_axil.awready),
    .payload_i({s_axil.awaddr, s_axil.awprot}),
    .stable_fail_o(aw_stable_fail), .stall_fail_o(aw_stall_fail));

  f_axil_chan_stable #(.PAYLOAD_WIDTH(DATA_WIDTH + STRB_WIDTH), .AS_ASSERT(1'b0),
    .MAX_STALL(MAX_STALL), .F_ASSERT_EN(F_ASSERT_EN)) u_w (
    .clk(clk), .rst(rst), .past_ok_i(past_ok),
    .valid_i(s_axil.wvalid), .ready_i(s_axil.wready),
    .payload_i({s_axil.wdata, s_axil.wstrb}),
    .stable_fail_o(w_stable_fail), .stall_fail_o(w_stall_fail));

  f_axil_chan_stable #(.PAYLOAD_WIDTH(ADDR_WIDTH + 3), .AS_ASSERT(1'b0),
    .MAX_STALL(MAX_STALL), .F_ASSERT_EN(F_ASSERT_EN)) u_ar (
    .clk(clk), .rst(rst), .past_ok_i(past_ok),
    .valid_i(s_axil.arvalid), .ready_i(s_axil.arready),
    .payload_i({s_axil.araddr, s_axil.arprot}),
    .stable_fail_o(ar_stable_fail), .stall_fail_o(ar_stall_fail));

  f_axil_chan_stable #(.PAYLOAD_WIDTH(2), .AS_ASSERT(1'b1),
    .MAX_STALL(MAX_STALL), .F_ASSERT_EN(F_ASSERT_EN)) u_b (
    .clk(clk), .rst(rst), .past_ok_i(past_ok),
    .valid_i(s_axil.bvalid), .ready_i(s_axil.bready),
    .payload_i(s_axil.bresp),
    .stable_fail_o(b_stable_fail), .stall_fail_o(b_stall_fail));

  f_axil_chan_stable #(.PAYLOAD_WIDTH(DATA_WIDTH + 2), .AS_ASSERT(1'b1),
    .MAX_STALL(MAX_STALL), .F_ASSERT_EN(F_ASSERT_EN)) u_r (
    .clk(clk), .rst(rst), .past_ok_i(past_ok),
    .valid_i(s_axil.rvalid), .ready_i(s_axil.rready),
    .payload_i({s_axil.rdata, s_axil.rresp}),
    .stable_fail_o(r_stable_fail), .stall_fail_o(r_stall_fail));

  assign f_assert_fail = f_b_early || f_r_early || f_post_rst || f_rd_dly || f_wr_dly ||
                         b_stable_fail || r_stable_fail ||
                         aw_stall_fail || w_stall_fail || ar_stall_fail;
  assign f_assume_fail = f_req_in_rst || f_ovf ||
                         aw_stable_fail || w_stable_fail || ar_stable_fail ||
                         b_stall_fail || r_stall_fail;

  if (F_ASSERT_EN) begin : g_sva
    always_ff @(posedge clk) begin
      a_bvalid_early: assert (!f_b_early);
      a_rvalid_early: assert (!f_r_early);
      a_resp_post_rst: assert (!f_post_rst);
      a_rd_delay: assert (!f_rd_dly);
      a_wr_delay: assert (!f_wr_dly);
      m_req_in_rst: assume (!f_req_in_rst);
      m_no_overflow: assume (!f_ovf);
    end
    c_read_done:  cover property (@(posedge clk) rst && r_hs);
    c_write_done: cover property (@(posedge clk) rst && b_hs);
    c_rd_wr_both: cover property (@(posedge clk) rst && ar_q != '0 && aw_q != '0 && w_q != '0);
    c_aw_two:     cover property (@(posedge clk) rst && aw_q == CW'(2));
  end

endmodule
